// File: rtl/uart_ctrl.sv
// uart_ctrl: bus-side UART controller with baud tick, RX/TX FIFOs, TX handshake FSM and 4 registers.
// Define UART_CTRL_IRQ_EN to build the interrupt logic and the CTRL irq-enable bits.
module uart_ctrl #(
  parameter int BUS_CLK    = 10_000_000,
  parameter int BAUD       = 9_600,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  addr,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        baud_en,
  input  logic [7:0]  rx_din,
  input  logic        rx_recv,
  input  logic        rx_err,
  output logic [7:0]  tx_dout,
  output logic        tx_send,
  input  logic        tx_busy,
  output logic        irq
);
  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [15:0] DIV_RST = 16'(BUS_CLK / (BAUD * 8) - 1);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_DRAIN} tx_state_e;
  tx_state_e tx_state_q, tx_state_d;

  logic [31:0] rd_data_q;
  logic        baud_en_q;
  logic [15:0] baud_cnt_q, div_q;
  logic        ctrl_en_q, rx_overrun_q, frame_err_q, rx_recv_q;
  logic [7:0]  tx_dout_q;
  logic [8:0]  rx_mem_q [FIFO_DEPTH];
  logic [7:0]  tx_mem_q [FIFO_DEPTH];
  logic [AW:0] rx_wptr_q, rx_rptr_q, tx_wptr_q, tx_rptr_q;
  logic        rx_irq_en, tx_irq_en;

  logic [1:0]  sel;
  logic        data_rd, data_wr, stat_wr, ctrl_wr, div_wr;
  logic        rx_empty, rx_full, tx_empty, tx_full, tx_active;
  logic        rx_edge, rx_pop, rx_push, rx_drop, tx_push, tx_pop;
  logic [31:0] status;
  logic        unused_bits;

  assign sel     = addr[3:2];
  assign data_rd = rd_en && (sel == 2'd0);
  assign data_wr = wr_en && (sel == 2'd0);
  assign stat_wr = wr_en && (sel == 2'd1);
  assign ctrl_wr = wr_en && (sel == 2'd2);
  assign div_wr  = wr_en && (sel == 2'd3);
  assign unused_bits = ^{wr_data[31:16], addr[1:0]};

  assign rx_empty = (rx_wptr_q == rx_rptr_q);
  assign rx_full  = (rx_wptr_q[AW] != rx_rptr_q[AW]) && (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]);
  assign tx_empty = (tx_wptr_q == tx_rptr_q);
  assign tx_full  = (tx_wptr_q[AW] != tx_rptr_q[AW]) && (tx_wptr_q[AW-1:0] == tx_rptr_q[AW-1:0]);

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign rx_edge = rx_recv && !rx_recv_q && ctrl_en_q;
  assign rx_pop  = data_rd && !rx_empty;
  assign rx_push = rx_edge && (!rx_full || rx_pop);
  assign rx_drop = rx_edge && rx_full && !rx_pop;
  assign tx_push = data_wr && !tx_full;

  assign tx_active = (tx_state_q != TX_IDLE);
  assign status = {25'b0, tx_active, frame_err_q, rx_overrun_q, tx_empty, tx_full, rx_full, !rx_empty};

  always_comb begin
    tx_state_d = tx_state_q;
    tx_pop     = 1'b0;
    tx_send    = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (ctrl_en_q && !tx_empty && !tx_busy) begin
          tx_pop     = 1'b1;
          tx_state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        tx_send = 1'b1;
        if (tx_busy) tx_state_d = TX_DRAIN;
      end
      TX_DRAIN: begin
        if (!tx_busy) tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) tx_state_q <= TX_IDLE;
    else        tx_state_q <= tx_state_d;
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wptr_q[AW-1:0]] <= {rx_err, rx_din};
    if (tx_push) tx_mem_q[tx_wptr_q[AW-1:0]] <= wr_data[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q    <= '0;
      baud_en_q    <= 1'b0;
      baud_cnt_q   <= '0;
      div_q        <= DIV_RST;
      ctrl_en_q    <= 1'b0;
      rx_overrun_q <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_recv_q    <= 1'b0;
      tx_dout_q    <= '0;
      rx_wptr_q    <= '0;
      rx_rptr_q    <= '0;
      tx_wptr_q    <= '0;
      tx_rptr_q    <= '0;
    end else begin
      if (rd_en) begin
        case (sel)
          2'd0:    rd_data_q <= rx_empty ? 32'h8000_0000 : {23'b0, rx_mem_q[rx_rptr_q[AW-1:0]]};
          2'd1:    rd_data_q <= status;
          2'd2:    rd_data_q <= {29'b0, tx_irq_en, rx_irq_en, ctrl_en_q};
          default: rd_data_q <= {16'b0, div_q};
        endcase
      end
      if (!ctrl_en_q || div_wr) begin
        baud_cnt_q <= '0;
        baud_en_q  <= 1'b0;
      end else if (baud_cnt_q == div_q) begin
        baud_cnt_q <= '0;
        baud_en_q  <= 1'b1;
      end else begin
        baud_cnt_q <= baud_cnt_q + 16'd1;
        baud_en_q  <= 1'b0;
      end
      // Setting a sticky flag takes priority over a W1C in the same cycle.
      rx_overrun_q <= rx_drop || (rx_overrun_q && !(stat_wr && wr_data[4]));
      frame_err_q  <= (rx_edge && rx_err) || (frame_err_q && !(stat_wr && wr_data[5]));
      rx_recv_q    <= rx_recv;
      if (ctrl_wr) ctrl_en_q <= wr_data[0];
      if (div_wr)  div_q     <= wr_data[15:0];
      if (rx_push) rx_wptr_q <= rx_wptr_q + PTR_ONE;
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + PTR_ONE;
      if (tx_push) tx_wptr_q <= tx_wptr_q + PTR_ONE;
      if (tx_pop) begin
        tx_rptr_q <= tx_rptr_q + PTR_ONE;
        tx_dout_q <= tx_mem_q[tx_rptr_q[AW-1:0]];
      end
    end
  end

`ifdef UART_CTRL_IRQ_EN
  logic rx_irq_en_q, tx_irq_en_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_irq_en_q <= 1'b0;
      tx_irq_en_q <= 1'b0;
    end else if (ctrl_wr) begin
      rx_irq_en_q <= wr_data[1];
      tx_irq_en_q <= wr_data[2];
    end
  end

  assign rx_irq_en = rx_irq_en_q;
  assign tx_irq_en = tx_irq_en_q;
  assign irq = (rx_irq_en_q && !rx_empty) || (tx_irq_en_q && tx_empty && !tx_active) ||
               (rx_irq_en_q && rx_overrun_q);
`else
  assign rx_irq_en = 1'b0;
  assign tx_irq_en = 1'b0;
  assign irq       = 1'b0;
`endif

  assign rd_data = rd_data_q;
  assign baud_en = baud_en_q;
  assign tx_dout = tx_dout_q;
endmodule

// File: tb/tb_uart_ctrl.sv
// Self-checking bench for uart_ctrl: queue-based reference model compared every cycle,
// directed register scenarios with literal expectations, then randomized traffic.
module tb_uart_ctrl;
  localparam int DEPTH = 8;

  logic        clk, rst_n, rd_en, wr_en, rx_recv, rx_err, tx_busy;
  logic [3:0]  addr;
  logic [31:0] wr_data, rd_data;
  logic [7:0]  rx_din, tx_dout;
  logic        baud_en, tx_send, irq;

  uart_ctrl #(.BUS_CLK(10_000_000), .BAUD(9_600), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .rd_en(rd_en), .wr_en(wr_en),
    .wr_data(wr_data), .rd_data(rd_data), .baud_en(baud_en), .rx_din(rx_din),
    .rx_recv(rx_recv), .rx_err(rx_err), .tx_dout(tx_dout), .tx_send(tx_send),
    .tx_busy(tx_busy), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: FIFOs as queues, baud as modulo of enabled cycles.
  logic [8:0]  rxq[$];
  logic [7:0]  txq[$];
  logic [7:0]  sent[$];
  bit          live = 0;
  bit          m_en, m_rxie, m_txie, m_ovr, m_ferr, m_baud, m_send, m_irq, prev_recv, m_edge;
  int unsigned m_div, since;
  int          m_phase, rx_sz, tx_sz;
  logic [31:0] m_rd;
  logic [7:0]  m_dout;
  logic [1:0]  m_sel;

  always @(posedge clk) begin
    if (!rst_n) begin
      rxq.delete(); txq.delete();
      m_en = 0; m_rxie = 0; m_txie = 0; m_ovr = 0; m_ferr = 0; m_baud = 0;
      m_send = 0; m_irq = 0; prev_recv = 0; m_div = 129; since = 0;
      m_phase = 0; m_rd = '0; m_dout = '0;
      live = 1;
    end else begin
      rx_sz = rxq.size();
      tx_sz = txq.size();
      m_sel = addr[3:2];
      if (rd_en) begin
        case (m_sel)
          2'd0: m_rd = (rx_sz == 0) ? 32'h8000_0000 : {23'b0, rxq.pop_front()};
          2'd1: m_rd = {25'b0, m_phase != 0, m_ferr, m_ovr, tx_sz == 0, tx_sz == DEPTH,
                        rx_sz == DEPTH, rx_sz != 0};
          2'd2: m_rd = {29'b0, m_txie, m_rxie, m_en};
          default: m_rd = m_div;
        endcase
      end
      if (!m_en || (wr_en && m_sel == 2'd3)) begin
        m_baud = 0; since = 0;
      end else begin
        m_baud = (since % (m_div + 1)) == m_div;
        since++;
      end
      m_edge = rx_recv && !prev_recv && m_en;
      prev_recv = rx_recv;
      if (wr_en && m_sel == 2'd1) begin
        if (wr_data[4]) m_ovr = 0;
        if (wr_data[5]) m_ferr = 0;
      end
      if (m_edge) begin
        if (rx_err) m_ferr = 1;
        if (rxq.size() < DEPTH) rxq.push_back({rx_err, rx_din});
        else m_ovr = 1;
      end
      case (m_phase)
        0: if (m_en && tx_sz > 0 && !tx_busy) begin m_dout = txq.pop_front(); m_phase = 1; end
        1: if (tx_busy) m_phase = 2;
        default: if (!tx_busy) m_phase = 0;
      endcase
      if (wr_en && m_sel == 2'd0 && tx_sz < DEPTH) txq.push_back(wr_data[7:0]);
      if (wr_en && m_sel == 2'd2) begin
        m_en = wr_data[0];
`ifdef UART_CTRL_IRQ_EN
        m_rxie = wr_data[1];
        m_txie = wr_data[2];
`endif
      end
      if (wr_en && m_sel == 2'd3) m_div = wr_data[15:0];
      m_send = (m_phase == 1);
      m_irq = (m_rxie && rxq.size() > 0) || (m_txie && txq.size() == 0 && m_phase == 0) ||
              (m_rxie && m_ovr);
    end
  end

  always @(negedge clk) begin
    if (live) begin
      check("rd_data", rd_data, m_rd);
      check("baud_en", {31'b0, baud_en}, {31'b0, m_baud});
      check("tx_send", {31'b0, tx_send}, {31'b0, m_send});
      check("tx_dout", {24'b0, tx_dout}, {24'b0, m_dout});
      check("irq", {31'b0, irq}, {31'b0, m_irq});
    end
  end

  // uart_tx stand-in: acknowledges each tx_send with a busy window of random length.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_send === 1'b1 && !tx_busy) begin
        sent.push_back(tx_dout);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        tx_busy = 1'b1;
        repeat ($urandom_range(2, 8)) @(negedge clk);
        tx_busy = 1'b0;
      end
    end
  end

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    addr = a; wr_data = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    addr = a; rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    d = rd_data;
  endtask

  task automatic rx_pulse(input logic [7:0] b, input logic e);
    rx_din = b; rx_err = e; rx_recv = 1'b1;
    @(negedge clk);
    rx_recv = 1'b0;
    @(negedge clk);
  endtask

  logic [31:0] d;
  int          pulses[$];
  bit          done;

  initial begin
    rst_n = 1'b0; addr = '0; rd_en = 1'b0; wr_en = 1'b0; wr_data = '0;
    rx_din = '0; rx_recv = 1'b0; rx_err = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    bus_read(4'hC, d); check("div_reset", d, 32'd129);
    bus_read(4'h8, d); check("ctrl_reset", d, 32'h0);
    bus_read(4'h4, d); check("status_reset", d, 32'h08);
    bus_read(4'h0, d); check("data_empty_reset", d, 32'h8000_0000);

    bus_write(4'hC, 32'd3);
    bus_write(4'h8, 32'd1);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (baud_en) pulses.push_back(c);
    end
    check("baud_count", pulses.size(), 10);
    for (int i = 1; i < 4 && i < pulses.size(); i++)
      check("baud_gap", pulses[i] - pulses[i-1], 4);
    bus_read(4'hC, d); check("div_readback", d, 32'd3);

    sent.delete();
    bus_write(4'h0, 32'h55);
    bus_write(4'h0, 32'hA3);
    done = 0;
    for (int i = 0; i < 600; i++) begin
      if (txq.size() == 0 && m_phase == 0 && !tx_busy) begin done = 1; break; end
      @(negedge clk);
    end
    check("tx_drain_done", done, 1);
    check("tx_send_count", sent.size(), 2);
    if (sent.size() == 2) begin
      check("tx_byte0", sent[0], 32'h55);
      check("tx_byte1", sent[1], 32'hA3);
    end
    bus_read(4'h4, d); check("tx_empty_after", d[3], 1);

    for (int i = 0; i < 9; i++) rx_pulse(8'(i), 1'b0);
    bus_read(4'h4, d); check("rx_full_overrun", d & 32'h13, 32'h13);
    bus_write(4'h4, 32'h10);
    bus_read(4'h4, d); check("overrun_w1c", d & 32'h12, 32'h02);

    addr = 4'h0; rd_en = 1'b1; rx_din = 8'h09; rx_err = 1'b0; rx_recv = 1'b1;
    @(negedge clk);
    rd_en = 1'b0; rx_recv = 1'b0;
    check("simul_pop", rd_data, 32'h00);
    bus_read(4'h4, d); check("simul_no_overrun", d & 32'h13, 32'h03);
    for (int i = 1; i < 8; i++) begin
      bus_read(4'h0, d); check("rx_order", d, i);
    end
    bus_read(4'h0, d); check("rx_simul_byte", d, 32'h09);
    bus_read(4'h0, d); check("data_empty", d, 32'h8000_0000);

    rx_pulse(8'h7E, 1'b1);
    bus_read(4'h0, d); check("frame_err_data", d, 32'h0000_017E);
    bus_read(4'h4, d); check("frame_err_flag", d[5], 1);
    bus_write(4'h4, 32'h20);
    bus_read(4'h4, d); check("frame_err_w1c", d[5], 0);

    bus_write(4'h8, 32'h3);
    bus_read(4'h8, d);
`ifdef UART_CTRL_IRQ_EN
    check("ctrl_irq_bits", d, 32'h3);
    rx_pulse(8'h11, 1'b0);
    check("irq_rx_set", irq, 1);
    bus_read(4'h0, d);
    check("irq_rx_clear", irq, 0);
`else
    check("ctrl_irq_bits", d, 32'h1);
    rx_pulse(8'h11, 1'b0);
    check("irq_tied_low", irq, 0);
    bus_read(4'h0, d);
    check("irq_tied_low2", irq, 0);
`endif
    bus_write(4'h8, 32'h1);

    bus_write(4'h0, 32'hC3);
    done = 0;
    for (int i = 0; i < 100; i++) begin
      if (tx_send) begin done = 1; break; end
      @(negedge clk);
    end
    check("tx_send_seen", done, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("reset_aborts_send", tx_send, 0);
    bus_write(4'hC, $urandom_range(0, 5));
    bus_write(4'h8, 32'h7);

    for (int c = 0; c < 4000; c++) begin
      rd_en = 1'b0; wr_en = 1'b0;
      case ($urandom % 16)
        0, 1, 2: begin
          rd_en = 1'b1; addr = 4'($urandom_range(0, 3) * 4);
        end
        3, 4: begin
          wr_en = 1'b1;
          case ($urandom % 8)
            0, 1, 2, 3: begin addr = 4'h0; wr_data = $urandom; end
            4: begin addr = 4'h4; wr_data = $urandom; end
            5, 6: begin
              addr = 4'h8;
              wr_data = ($urandom % 8 == 0) ? 32'h0 : (($urandom & 32'h6) | 32'h1);
            end
            default: begin addr = 4'hC; wr_data = $urandom_range(0, 5); end
          endcase
        end
        default: ;
      endcase
      if (rx_recv) rx_recv = ($urandom % 2 == 0);
      else if ($urandom % 6 == 0) begin
        rx_recv = 1'b1; rx_din = 8'($urandom); rx_err = ($urandom % 8 == 0);
      end
      @(negedge clk);
    end
    rd_en = 1'b0; wr_en = 1'b0; rx_recv = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
